// File: rtl/gpio_config_loader.sv
// gpio_config_loader: streams per-pad GPIO config words, highest pad first,
// onto the serial data/clock chain, then strobes serial_load.
module gpio_config_loader #(
   parameter int NUM_PADS = 38,
   parameter int CFG_BITS = 13,
   parameter int CLK_DIV  = 4,
   parameter int IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic [IDX_W-1:0]    cfg_index,
   input  logic [CFG_BITS-1:0] cfg_data,
   output logic                serial_data_out,
   output logic                serial_clock,
   output logic                serial_load,
   output logic                busy,
   output logic                done
);

   localparam int BCW = $clog2(CFG_BITS + 1);
   localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADS - 1);
   localparam logic [BCW-1:0]   LAST_BIT = BCW'(CFG_BITS - 1);
   localparam logic [DCW-1:0]   LAST_DIV = DCW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LOAD,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [CFG_BITS-1:0] r_shift;
   logic [BCW-1:0]      r_bit_cnt;
   logic [DCW-1:0]      r_div_cnt;
   logic [IDX_W-1:0]    r_index;
   logic                r_sclk;
   logic                r_load;
   logic                r_busy;
   logic                r_done;

   logic                w_div_last;
   logic                w_bit_last;
   logic                w_pad_last;
   logic [CFG_BITS-1:0] w_shift_nxt;

   assign w_div_last  = (r_div_cnt == LAST_DIV);
   assign w_bit_last  = (r_bit_cnt == LAST_BIT);
   assign w_pad_last  = (r_index == '0);
   assign w_shift_nxt = r_shift << 1;

   // Data bit is the shift register MSB, itself a flop, so it only moves
   // on the edge that loads a word or drops serial_clock.
   assign serial_data_out = r_shift[CFG_BITS-1];
   assign serial_clock    = r_sclk;
   assign serial_load     = r_load;
   assign busy            = r_busy;
   assign done            = r_done;
   assign cfg_index       = r_index;

   // Chain load sequencer: fetch word, shift it out MSB first, next pad.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
         r_index   <= LAST_IDX;
         r_sclk    <= 1'b0;
         r_load    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_index <= LAST_IDX;
               if (start) begin
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            // cfg_index is stable here; the registered read lands next cycle
            S_FETCH: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_shift   <= cfg_data;
               r_bit_cnt <= '0;
               r_div_cnt <= '0;
               r_sclk    <= 1'b0;
               r_state   <= S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
               if (w_div_last) begin
                  r_div_cnt <= '0;
                  r_sclk    <= 1'b1;
                  r_state   <= S_SHIFT_HI;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_SHIFT_HI: begin
               if (w_div_last) begin
                  r_div_cnt <= '0;
                  r_sclk    <= 1'b0;
                  r_shift   <= w_shift_nxt;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (!w_bit_last) begin
                     r_state <= S_SHIFT_LO;
                  end else if (w_pad_last) begin
                     r_load  <= 1'b1;
                     r_state <= S_LOAD;
                  end else begin
                     r_index <= r_index - 1'b1;
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_LOAD: begin
               if (w_div_last) begin
                  r_div_cnt <= '0;
                  r_load    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            // start is deliberately ignored here
            S_DONE: begin
               r_index <= LAST_IDX;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_config_loader.sv
// tb_gpio_config_loader: directed checks on three configurations
// (2x4 div1, default 38x13 div4, 2x4 div3) with chain monitors.
module tb_gpio_config_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tot  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- small: 2 pads, 4 bits, div 1 ----------------
   logic       rst_s, start_s, sdo_s, sclk_s, load_s, busy_s, done_s;
   logic [0:0] idx_s;
   logic [3:0] data_s;
   logic [3:0] mem_s [2];

   gpio_config_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) u_s (
      .clock(clk), .reset(rst_s), .start(start_s),
      .cfg_index(idx_s), .cfg_data(data_s),
      .serial_data_out(sdo_s), .serial_clock(sclk_s),
      .serial_load(load_s), .busy(busy_s), .done(done_s)
   );

   always @(posedge clk) data_s <= mem_s[idx_s];

   int         rises_s  = 0;
   int         ld_s     = 0;
   int         dn_s     = 0;
   logic [7:0] bits_s   = '0;
   logic       p_sclk_s = 1'b0;

   always @(negedge clk) begin
      p_sclk_s <= sclk_s;
      if (sclk_s && !p_sclk_s) begin
         rises_s <= rises_s + 1;
         bits_s  <= {bits_s[6:0], sdo_s};
      end
      if (load_s) ld_s <= ld_s + 1;
      if (done_s) dn_s <= dn_s + 1;
   end

   // ---------------- default: 38 pads, 13 bits, div 4 ----------------
   localparam int NB = 38 * 13;
   logic        rst_d, start_d, sdo_d, sclk_d, load_d, busy_d, done_d;
   logic [5:0]  idx_d;
   logic [12:0] data_d;
   logic [12:0] mem_d [38];

   gpio_config_loader u_d (
      .clock(clk), .reset(rst_d), .start(start_d),
      .cfg_index(idx_d), .cfg_data(data_d),
      .serial_data_out(sdo_d), .serial_clock(sclk_d),
      .serial_load(load_d), .busy(busy_d), .done(done_d)
   );

   always @(posedge clk) data_d <= mem_d[idx_d];

   int          rises_d  = 0;
   int          dn_d     = 0;
   logic        p_sclk_d = 1'b0;
   logic        p_load_d = 1'b0;
   logic [NB-1:0] chain_d = '0;
   logic [NB-1:0] latch_d = '0;

   // Model chain: new bit enters at pad 0 end, pad k sits at [k*13 +: 13]
   always @(negedge clk) begin
      p_sclk_d <= sclk_d;
      p_load_d <= load_d;
      if (sclk_d && !p_sclk_d) begin
         rises_d <= rises_d + 1;
         chain_d <= {chain_d[NB-2:0], sdo_d};
      end
      if (load_d && !p_load_d) latch_d <= chain_d;
      if (done_d) dn_d <= dn_d + 1;
   end

   // ---------------- div3: 2 pads, 4 bits, div 3 ----------------
   logic       rst_c, start_c, sdo_c, sclk_c, load_c, busy_c, done_c;
   logic [0:0] idx_c;
   logic [3:0] data_c;
   logic [3:0] mem_c [2];

   gpio_config_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(3)) u_c (
      .clock(clk), .reset(rst_c), .start(start_c),
      .cfg_index(idx_c), .cfg_data(data_c),
      .serial_data_out(sdo_c), .serial_clock(sclk_c),
      .serial_load(load_c), .busy(busy_c), .done(done_c)
   );

   always @(posedge clk) data_c <= mem_c[idx_c];

   int         rises_c   = 0;
   int         run_c     = 0;
   int         sdo_run_c = 0;
   int         hi_min_c  = 999;
   int         hi_max_c  = 0;
   int         lo_min_c  = 999;
   int         lo_max_c  = 0;
   int         sdo_min_c = 999;
   int         chg_hi_c  = 0;
   int         ld_c      = 0;
   logic [7:0] bits_c    = '0;
   logic       p_sclk_c  = 1'b0;
   logic       p_sdo_c   = 1'b0;

   // Phase lengths; low phases right after a word fetch are excluded
   always @(negedge clk) begin
      p_sclk_c  <= sclk_c;
      p_sdo_c   <= sdo_c;
      run_c     <= (sclk_c != p_sclk_c) ? 1 : run_c + 1;
      sdo_run_c <= (sdo_c != p_sdo_c) ? 1 : sdo_run_c + 1;
      if (!sclk_c && p_sclk_c) begin
         hi_min_c <= (run_c < hi_min_c) ? run_c : hi_min_c;
         hi_max_c <= (run_c > hi_max_c) ? run_c : hi_max_c;
      end
      if (sclk_c && !p_sclk_c) begin
         rises_c   <= rises_c + 1;
         bits_c    <= {bits_c[6:0], sdo_c};
         sdo_min_c <= (sdo_run_c < sdo_min_c) ? sdo_run_c : sdo_min_c;
         if (rises_c % 4 != 0) begin
            lo_min_c <= (run_c < lo_min_c) ? run_c : lo_min_c;
            lo_max_c <= (run_c > lo_max_c) ? run_c : lo_max_c;
         end
      end
      if (sclk_c && p_sclk_c && (sdo_c !== p_sdo_c)) chg_hi_c <= chg_hi_c + 1;
      if (load_c) ld_c <= ld_c + 1;
   end

   // ---------------- directed sequence ----------------
   initial begin
      int b_r, b_l, b_d;
      int cyc, done_at;

      rst_s = 1'b1; rst_d = 1'b1; rst_c = 1'b1;
      start_s = 1'b0; start_d = 1'b0; start_c = 1'b0;
      mem_s[1] = 4'hA; mem_s[0] = 4'h3;
      mem_c[1] = 4'h6; mem_c[0] = 4'h9;
      for (int i = 0; i < 38; i++) mem_d[i] = 13'($urandom);

      repeat (3) tick();
      rst_s = 1'b0; rst_d = 1'b0; rst_c = 1'b0;

      // Idle after reset, no start
      repeat (100) tick();
      chk("rst_idx_d", idx_d, 37);
      chk("rst_out_d", {sdo_d, sclk_d, load_d, busy_d, done_d}, 0);
      chk("rst_rises_d", rises_d, 0);
      chk("rst_idx_s", idx_s, 1);
      chk("rst_out_s", {sdo_s, sclk_s, load_s, busy_s, done_s}, 0);
      chk("rst_rises_s", rises_s, 0);
      chk("rst_out_c", {sdo_c, sclk_c, load_c, busy_c, done_c}, 0);
      chk("rst_rises_c", rises_c, 0);

      // Small config, cycle-exact busy/load/done
      b_r = rises_s; b_l = ld_s; b_d = dn_s;
      start_s = 1'b1; tick(); start_s = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         chk($sformatf("busy_s@%0d", c), busy_s, (c <= 21));
         chk($sformatf("load_s@%0d", c), load_s, (c == 21));
         chk($sformatf("done_s@%0d", c), done_s, (c == 22));
         tick();
      end
      chk("bits_s", bits_s, 8'hA3);
      chk("rises_s", rises_s - b_r, 8);
      chk("ld_s", ld_s - b_l, 1);
      chk("idx_back_s", idx_s, 1);

      // Extra start mid-load and start held across done
      b_r = rises_s; b_l = ld_s; b_d = dn_s;
      start_s = 1'b1; tick(); start_s = 1'b0;
      repeat (4) tick();
      start_s = 1'b1; tick(); start_s = 1'b0;
      repeat (14) tick();
      start_s = 1'b1; tick(); tick();
      chk("held_done_s", done_s, 1);
      tick(); start_s = 1'b0;
      chk("held_busy23_s", busy_s, 0);
      repeat (5) tick();
      chk("held_busy28_s", busy_s, 0);
      chk("held_dn_s", dn_s - b_d, 1);
      chk("held_ld_s", ld_s - b_l, 1);
      chk("held_rises_s", rises_s - b_r, 8);

      // Reset during SHIFT_HI of pad 1, then a fresh full load
      b_l = ld_s; b_d = dn_s;
      start_s = 1'b1; tick(); start_s = 1'b0;
      repeat (3) tick();
      chk("pre_rst_sclk_s", sclk_s, 1);
      chk("pre_rst_idx_s", idx_s, 1);
      rst_s = 1'b1; tick();
      chk("abort_out_s", {sdo_s, sclk_s, load_s, busy_s, done_s}, 0);
      chk("abort_idx_s", idx_s, 1);
      rst_s = 1'b0;
      repeat (5) tick();
      chk("abort_ld_s", ld_s - b_l, 0);
      chk("abort_busy_s", busy_s, 0);
      b_r = rises_s;
      start_s = 1'b1; tick(); start_s = 1'b0;
      repeat (22) tick();
      chk("reload_bits_s", bits_s, 8'hA3);
      chk("reload_rises_s", rises_s - b_r, 8);
      chk("reload_ld_s", ld_s - b_l, 1);
      chk("reload_dn_s", dn_s - b_d, 1);

      // Default config against the model chain
      b_r = rises_d; b_d = dn_d;
      start_d = 1'b1; tick(); start_d = 1'b0;
      cyc = 1; done_at = 0;
      while (cyc < 5000 && done_at == 0) begin
         if (done_d) done_at = cyc;
         else begin
            tick();
            cyc++;
         end
      end
      chk("lat_d", done_at, 4033);
      tick();
      chk("busy_end_d", busy_d, 0);
      chk("rises_d", rises_d - b_r, 494);
      chk("dn_d", dn_d - b_d, 1);
      for (int i = 0; i < 38; i++) begin
         chk($sformatf("pad%0d_d", i), latch_d[i*13 +: 13], mem_d[i]);
      end

      // CLK_DIV=3 phase widths
      start_c = 1'b1; tick(); start_c = 1'b0;
      cyc = 1; done_at = 0;
      while (cyc < 200 && done_at == 0) begin
         if (done_c) done_at = cyc;
         else begin
            tick();
            cyc++;
         end
      end
      chk("lat_c", done_at, 56);
      tick();
      chk("bits_c", bits_c, 8'h69);
      chk("rises_c", rises_c, 8);
      chk("hi_min_c", hi_min_c, 3);
      chk("hi_max_c", hi_max_c, 3);
      chk("lo_min_c", lo_min_c, 3);
      chk("lo_max_c", lo_max_c, 3);
      chk("ld_w_c", ld_c, 3);
      chk("chg_hi_c", chg_hi_c, 0);
      chk("sdo_setup_c", (sdo_min_c >= 3), 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
